// File: rtl/score_digit_scan_pkg.sv
// Shared constants for the score digit scanner: segment bit positions,
// special decode patterns, scan state encoding and a segment-building helper.
package score_digit_scan_pkg;

  // Segment bit positions within the 7-bit segment bus (bit6=a ... bit0=g).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Special segment patterns.
  localparam logic [6:0] SEG_CODE_BLANK = 7'h00;
  localparam logic [6:0] SEG_CODE_DASH  = 7'(1) << SEG_G;
  localparam logic [6:0] SEG_CODE_ALL   = 7'h7F;

  // BCD codes with special meaning: 10..14 render as a dash, 15 as blank.
  localparam logic [3:0] CODE_DASH_MIN = 4'hA;
  localparam logic [3:0] CODE_BLANK    = 4'hF;

  // Scan state encoding.
  localparam logic ST_BLANK_ENC = 1'b0;
  localparam logic ST_SHOW_ENC  = 1'b1;

  typedef enum logic {
    ST_BLANK = ST_BLANK_ENC,
    ST_SHOW  = ST_SHOW_ENC
  } state_t;

  // Builds a segment word from individual a..g flags using the bit positions above.
  function automatic logic [6:0] seg_set(input logic a, input logic b, input logic c,
                                         input logic d, input logic e, input logic f,
                                         input logic g);
    logic [6:0] s;
    s        = '0;
    s[SEG_A] = a;
    s[SEG_B] = b;
    s[SEG_C] = c;
    s[SEG_D] = d;
    s[SEG_E] = e;
    s[SEG_F] = f;
    s[SEG_G] = g;
    return s;
  endfunction

endpackage

// File: rtl/score_digit_scan_seg7_decoder.sv
// Combinational BCD-to-7-segment decoder shared by all scanned digits.
// 6 is drawn without segment a and 9 without segment d; 10..14 show a dash,
// 15 shows nothing.
module seg7_decoder
  import score_digit_scan_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // Map one BCD code to its segment pattern.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    seg = SEG_CODE_BLANK;
    case (code)
      4'd0:       seg = seg_set(H, H, H, H, H, H, L);
      4'd1:       seg = seg_set(L, H, H, L, L, L, L);
      4'd2:       seg = seg_set(H, H, L, H, H, L, H);
      4'd3:       seg = seg_set(H, H, H, H, L, L, H);
      4'd4:       seg = seg_set(L, H, H, L, L, H, H);
      4'd5:       seg = seg_set(H, L, H, H, L, H, H);
      4'd6:       seg = seg_set(L, L, H, H, H, H, H);
      4'd7:       seg = seg_set(H, H, H, L, L, L, L);
      4'd8:       seg = seg_set(H, H, H, H, H, H, H);
      4'd9:       seg = seg_set(H, H, H, L, L, H, H);
      CODE_BLANK: seg = SEG_CODE_BLANK;
      default:    seg = (code >= CODE_DASH_MIN) ? SEG_CODE_DASH : SEG_CODE_BLANK;
    endcase
  end

endmodule

// File: rtl/score_digit_scan.sv
// Time-multiplexed score display scanner. Latches a BCD score at frame
// boundaries and scans one digit at a time (BLANK gap, then SHOW dwell)
// through a single shared seg7_decoder. Digit 0 is the most significant
// digit, held in the MSBs of bcd_in, and is driven on digit_sel bit 0.
// Optional leading-zero blanking is enabled by defining SCORE_SCAN_LZB_EN.
module score_digit_scan
  import score_digit_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DWELL      = 16,
  parameter int unsigned GAP        = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ce,
  input  logic                    load_req,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic                    load_ack,
  input  logic                    lamp_test,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [6:0]              seg,
  output logic                    frame_end
);

  localparam int unsigned        IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]         GAP_LAST   = 8'(GAP - 1);
  localparam logic [7:0]         DWELL_LAST = 8'(DWELL - 1);

  state_t                  state;
  logic [7:0]              cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   nxt_mask;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [3:0]              cur_code;
  logic [6:0]              dec_seg;
  logic [6:0]              show_seg;

  // Pick the BCD code of the current digit out of the shadow score.
  always_comb begin
    cur_code = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_code = shadow[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  seg7_decoder u_dec (
    .code (cur_code),
    .seg  (dec_seg)
  );

  // Lamp test lights everything and overrides blanking; otherwise honour the mask.
  assign show_seg   = lamp_test ? SEG_CODE_ALL :
                      (blank_mask[idx] ? SEG_CODE_BLANK : dec_seg);
  assign sel_onehot = NUM_DIGITS'(1) << idx;

`ifdef SCORE_SCAN_LZB_EN
  // Blank digit i when it and every more significant digit are zero; the
  // least significant digit is always shown so a zero score reads "0".
  always_comb begin
    logic all_zero;
    nxt_mask = '0;
    all_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      all_zero    = all_zero && (bcd_in[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      nxt_mask[i] = all_zero;
    end
  end
`else
  // Leading zeros are displayed; the mask stays clear.
  assign nxt_mask = '0;
`endif

  // Scan FSM: BLANK gap and SHOW dwell per digit, frame wrap and score capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_BLANK;
      cnt        <= '0;
      idx        <= '0;
      // NOTE: the score shadow is reset so the first frame after reset shows zeros.
      shadow     <= '0;
      blank_mask <= '0;
      digit_sel  <= '0;
      seg        <= '0;
      load_ack   <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      load_ack  <= 1'b0;
      frame_end <= 1'b0;
      // Segments track lamp_test while a digit is lit, even between ce ticks.
      if (state == ST_SHOW) seg <= show_seg;
      if (ce) begin
        case (state)
          ST_BLANK: begin
            if (cnt == GAP_LAST) begin
              state     <= ST_SHOW;
              cnt       <= '0;
              digit_sel <= sel_onehot;
              seg       <= show_seg;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_SHOW: begin
            if (cnt == DWELL_LAST) begin
              state     <= ST_BLANK;
              cnt       <= '0;
              digit_sel <= '0;
              seg       <= '0;
              if (idx == LAST_IDX) begin
                idx       <= '0;
                frame_end <= 1'b1;
                if (load_req) begin
                  shadow     <= bcd_in;
                  blank_mask <= nxt_mask;
                  load_ack   <= 1'b1;
                end
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          default: state <= ST_BLANK;
        endcase
      end
    end
  end

endmodule
